// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_TICKS_DEFAULT = 87;

endpackage

// File: rtl/uart_rx_stream_if.sv
// Valid/ready byte stream between the UART receiver (master) and its consumer (slave).
interface uart_rx_stream_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_out;
  logic                      valid;
  logic                      ready;

  modport master (output data_out, output valid, input ready);
  modport slave  (input data_out, input valid, output ready);

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rxs
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = UART_TICKS_DEFAULT,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  uart_rx_stream_if.master  stream,
  output logic              busy,
  output logic              frame_err,
`ifdef UART_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              overrun
);

  localparam int TW = $clog2(TICKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  logic                      rxs;
  uart_rx_state_t            state, state_nxt;
  logic [TW-1:0]             tick_cnt, tick_nxt;
  logic [BW-1:0]             bit_idx, bit_nxt;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                      byte_done;
  logic                      ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad, par_bad_nxt;
  logic                      perr_nxt;
`endif

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rxs   (rxs)
  );

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift_reg;
    byte_done = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = 1'b0;
`endif
        if (!rxs) begin
          state_nxt = START;
          tick_nxt  = '0;
        end
      end
      // Start bit is re-checked mid-bit so short low glitches are ignored.
      START: begin
        if (tick_cnt == TICK_HALF) begin
          tick_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = rxs ? IDLE : DATA;
        end else begin
          tick_nxt = tick_cnt + TICK_ONE;
        end
      end
      DATA: begin
        if (tick_cnt == TICK_LAST) begin
          tick_nxt  = '0;
          shift_nxt = {rxs, shift_reg[UART_DATA_BITS-1:1]};
          bit_nxt   = bit_idx + BIT_ONE;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          tick_nxt = tick_cnt + TICK_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_cnt == TICK_LAST) begin
          tick_nxt  = '0;
          state_nxt = STOP;
          if (^{shift_reg, rxs}) begin
            perr_nxt    = 1'b1;
            par_bad_nxt = 1'b1;
          end
        end else begin
          tick_nxt = tick_cnt + TICK_ONE;
        end
      end
`endif
      STOP: begin
        if (tick_cnt == TICK_LAST) begin
          tick_nxt = '0;
          if (rxs) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            byte_done = !par_bad;
`else
            byte_done = 1'b1;
`endif
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          tick_nxt = tick_cnt + TICK_ONE;
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      tick_cnt        <= '0;
      bit_idx         <= '0;
      stream.data_out <= '0;
      stream.valid    <= 1'b0;
      frame_err       <= 1'b0;
      overrun         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad         <= 1'b0;
      parity_err      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_idx   <= bit_nxt;
      frame_err <= ferr_nxt;
      overrun   <= byte_done && stream.valid && !stream.ready;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_nxt;
      parity_err <= perr_nxt;
`endif
      // A completed byte may load in the same cycle the old one is consumed.
      if (byte_done && (!stream.valid || stream.ready)) begin
        stream.data_out <= shift_reg;
        stream.valid    <= 1'b1;
      end else if (stream.valid && stream.ready) begin
        stream.valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed self-checking bench for uart_rx_stream (8N1, optional even parity).
module tb_uart_rx_stream;
  import uart_pkg::*;

  localparam int TPB  = 87;
  localparam int HALF = TPB / 2 - 1;
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = 4 + HALF + 10 * TPB;
`else
  localparam int LAT  = 4 + HALF + 9 * TPB;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  bit   par_flip = 1'b0;
`endif

  uart_rx_stream_if sif ();

  uart_rx_stream #(.TICKS_PER_BIT(TPB), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .stream     (sif.master),
    .busy       (busy),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: inputs change at posedge+1, so the negedge sees what the DUT acts on.
  int         valid_cyc = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, busy_cnt = 0;
  int         rise_cyc = 0, widx = 0;
  logic       valid_q = 1'b0;
  logic [7:0] log_mem [0:63];

  always @(negedge clk) begin
    valid_q <= sif.valid;
    if (sif.valid) valid_cyc <= valid_cyc + 1;
    if (sif.valid && !valid_q) rise_cyc <= cyc;
    if (sif.valid && sif.ready) begin
      log_mem[widx[5:0]] <= sif.data_out;
      widx <= widx + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
  end

  int total = 0, bad = 0;
  int t_start = 0;
  int b_valid, b_ferr, b_ovr, b_perr, b_busy, b_widx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_valid = valid_cyc;
    b_ferr  = ferr_cnt;
    b_ovr   = ovr_cnt;
    b_perr  = perr_cnt;
    b_busy  = busy_cnt;
    b_widx  = widx;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    t_start = cyc;
    rx = 1'b0;
    tick_n(TPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick_n(TPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    tick_n(TPB);
`endif
    rx = stop_v;
    tick_n(TPB);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] last_byte();
    return log_mem[(widx - 1) & 63];
  endfunction

  initial begin
    sif.ready = 1'b1;
    tick_n(3);
    chk("rst_valid", sif.valid, 0);
    chk("rst_data", sif.data_out, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b1;
    tick_n(5);

    // 1: A5 with consumer ready
    snap();
    send_frame(8'hA5, 1'b1);
    tick_n(TPB);
    chk("t1_latency", rise_cyc - t_start, LAT);
    chk("t1_valid_cycles", valid_cyc - b_valid, 1);
    chk("t1_count", widx - b_widx, 1);
    chk("t1_byte", last_byte(), 8'hA5);
    chk("t1_ferr", ferr_cnt - b_ferr, 0);
    chk("t1_busy", busy, 0);

    // 2: 20-clk glitch, then 3C
    snap();
    rx = 1'b0;
    tick_n(20);
    rx = 1'b1;
    tick_n(60);
    chk("t2_busy_seen", (busy_cnt - b_busy) > 0, 1);
    chk("t2_busy_low", busy, 0);
    chk("t2_no_valid", valid_cyc - b_valid, 0);
    chk("t2_no_ferr", ferr_cnt - b_ferr, 0);
    send_frame(8'h3C, 1'b1);
    tick_n(TPB);
    chk("t2_count", widx - b_widx, 1);
    chk("t2_byte", last_byte(), 8'h3C);

    // 3: 81 with bad stop bit, then 7E
    snap();
    send_frame(8'h81, 1'b0);
    tick_n(TPB);
    chk("t3_ferr_once", ferr_cnt - b_ferr, 1);
    chk("t3_no_valid", valid_cyc - b_valid, 0);
    chk("t3_busy", busy, 0);
    send_frame(8'h7E, 1'b1);
    tick_n(TPB);
    chk("t3_count", widx - b_widx, 1);
    chk("t3_byte", last_byte(), 8'h7E);

    // 4: overrun with consumer stalled
    sif.ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick_n(TPB);
    chk("t4_valid", sif.valid, 1);
    chk("t4_data", sif.data_out, 8'h11);
    chk("t4_ovr_once", ovr_cnt - b_ovr, 1);
    chk("t4_none_taken", widx - b_widx, 0);
    sif.ready = 1'b1;
    tick_n(3);
    chk("t4_count", widx - b_widx, 1);
    chk("t4_byte", last_byte(), 8'h11);
    chk("t4_valid_clr", sif.valid, 0);

    // 5: reset in the middle of FF's data bits, then 00
    snap();
    rx = 1'b0;
    tick_n(TPB);
    rx = 1'b1;
    tick_n(3 * TPB);
    chk("t5_busy_mid", busy, 1);
    reset = 1'b0;
    tick_n(2);
    reset = 1'b1;
    tick_n(1);
    chk("t5_busy_rst", busy, 0);
    chk("t5_data_rst", sif.data_out, 8'h00);
    tick_n(8 * TPB);
    chk("t5_no_byte", widx - b_widx, 0);
    chk("t5_no_ferr", ferr_cnt - b_ferr, 0);
    send_frame(8'h00, 1'b1);
    tick_n(TPB);
    chk("t5_count", widx - b_widx, 1);
    chk("t5_byte", last_byte(), 8'h00);
    chk("t5_valid_cycles", valid_cyc - b_valid, 1);

`ifdef UART_RX_PARITY_EN
    // 6: 07 with wrong then right even-parity bit
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tick_n(TPB);
    par_flip = 1'b0;
    chk("t6_perr_once", perr_cnt - b_perr, 1);
    chk("t6_no_valid", valid_cyc - b_valid, 0);
    snap();
    send_frame(8'h07, 1'b1);
    tick_n(TPB);
    chk("t6_no_perr", perr_cnt - b_perr, 0);
    chk("t6_count", widx - b_widx, 1);
    chk("t6_byte", last_byte(), 8'h07);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
